vid_pattern_gen: RTL and testbench
==================================

Name: vid_pattern_gen

Overview:
- Pixel-clock-domain video source driving the parallel RGB video interface consumed by the rgb2dvi encoder: vid_data, vid_active_video, vid_hsync and vid_vsync.
- Generates programmable raster timing and one of four test patterns.
- Stands in for the camera pipeline during HDMI bring-up and for display-path regression.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
PixelClk  in  1  pixel clock; all logic on rising edge
pRst  in  1  synchronous active-high reset
enable  in  1  run request; sampled only at frame boundary
pattern_sel  in  2  0 colour bars, 1 ramp, 2 checkerboard, 3 solid
solid_color  in  24  pattern 3 colour, {R,B,G}
vid_data  out  24  pixel, [23:16]=R, [15:8]=B, [7:0]=G
vid_active_video  out  1  data-enable
vid_hsync  out  1  horizontal sync, polarity HS_POL
vid_vsync  out  1  vertical sync, polarity VS_POL
frame_start  out  1  one-cycle pulse with the first active pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1.
- Counter wrap: h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 after V_TOTAL-1.
- States:
  - IDLE: counters held at (0,0); outputs idle.
  - RUN: counters free-run.
- IDLE->RUN on any cycle with enable=1. The counter at (0,0) in that cycle is the first raster position.
- RUN->IDLE only when counters wrap from (H_TOTAL-1, V_TOTAL-1) with enable=0. Frames are never truncated; enable changes mid-frame are ignored until the boundary.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), with transitions at h_cnt=0.
- Latency: all outputs are registered, exactly 1 cycle after the counter state that produced them. Sync, DE and data stay mutually aligned.
- Outside the active region, vid_data=0.
- Idle output levels (after reset and while IDLE): vid_data=0, vid_active_video=0, vid_hsync=~HS_POL, vid_vsync=~VS_POL, frame_start=0.
- pattern_sel and solid_color are latched when counters are at (0,0) in RUN, or on IDLE->RUN. Mid-frame changes have no effect until the next frame.
- Pattern 0, colour bars:
  - 8 bars, each BAR_W = H_ACTIVE/8 (integer floor).
  - Order: white FFFFFF, yellow FF00FF, cyan 00FFFF, green 0000FF, magenta FFFF00, red FF0000, blue 00FF00, black 000000 ({R,B,G} hex).
  - Pixels at x >= 8*BAR_W are black.
  - Bar index comes from a bar counter reset at h_cnt=0; no divider.
- Pattern 1, ramp: R=B=G=h_cnt[7:0]; wraps every 256 pixels.
- Pattern 2, checkerboard: white if (h_cnt[5] XOR v_cnt[5]) = 0, else black (32x32 squares).
- Pattern 3, solid: latched solid_color on every active pixel.
- frame_start is high in the same cycle vid_active_video first asserts for v_cnt=0, h_cnt=0.
- pRst mid-frame: on the next edge, counters go to (0,0), state goes to IDLE and outputs go idle. This holds regardless of enable; reset has priority over all other events.
- Counter widths are sized from the totals (clog2); no overflow for any legal parameter set.

Test Plan:
Small-raster parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); HS_POL=VS_POL=1.
1. Reset, then release with enable=1, pattern_sel=0 -> DE high 16 cycles, low 8, per line for 4 lines.
   - vid_data per pixel pair: FFFFFF, FF00FF, 00FFFF, 0000FF, FFFF00, FF0000, 00FF00, 000000.
   - frame_start pulses every 192 cycles, coincident with the first DE.
2. Sync timing -> hsync high on line-relative cycles 18-20 (first DE cycle = 0).
   - vsync high for exactly 48 cycles, starting 24+96 cycles after the frame's first DE.
   - During pRst=1: hsync=0, vsync=0.
3. pattern_sel 0->3 mid-frame with solid_color=123456 -> current frame keeps bars; next frame is all 123456 on active pixels, 0 in blanking.
4. enable deasserted mid-frame -> frame completes to its 192nd cycle, then outputs idle. Re-assert enable -> first DE one cycle later, frame_start with it.
5. pRst pulsed for 1 cycle mid-line while enable=1 -> next cycle outputs idle. Raster restarts from (0,0): DE high one cycle after reset release.
6. pattern_sel=1 and pattern_sel=2 with default parameters (1280x720) -> ramp pixel 300 = 2C2C2C (300 mod 256 = 44 = 0x2C). Checkerboard pixel (32,0) = 000000, pixel (32,32) = FFFFFF. H_TOTAL=1650, V_TOTAL=750.

Source files
------------

// File: rtl/vid_pattern_gen_if.sv
// Parallel RGB video bus from the test-pattern source to the DVI encoder.
// Pixel layout on vid_data is {R,B,G}.
interface vid_pattern_gen_if;
   logic [23:0] vid_data;
   logic        vid_active_video;
   logic        vid_hsync;
   logic        vid_vsync;
   logic        frame_start;

   modport master (
      output vid_data,
      output vid_active_video,
      output vid_hsync,
      output vid_vsync,
      output frame_start
   );

   modport slave (
      input vid_data,
      input vid_active_video,
      input vid_hsync,
      input vid_vsync,
      input frame_start
   );
endinterface

// File: rtl/vid_pattern_gen.sv
// Programmable raster timing generator with four test patterns (bars, ramp, checker, solid).
// All video outputs are registered one cycle after the raster position that produced them.
module vid_pattern_gen #(
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FP     = 110,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 220,
   parameter int unsigned V_ACTIVE = 720,
   parameter int unsigned V_FP     = 5,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 20,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic              PixelClk,
   input  logic              pRst,
   input  logic              enable,
   input  logic [1:0]        pattern_sel,
   input  logic [23:0]       solid_color,
   vid_pattern_gen_if.master vid
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One spare bit so the exclusive end of every interval is representable.
   localparam int unsigned HW      = $clog2(H_TOTAL + 1);
   localparam int unsigned VW      = $clog2(V_TOTAL + 1);
   localparam int unsigned BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] BAR_LAST = (BAR_W == 0) ? '0 : HW'(BAR_W - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]    BAR_NONE = 4'd8;

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   state_t        r_state;
   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic [1:0]    r_pat;
   logic [23:0]   r_solid;
   logic [3:0]    r_bar_idx;
   logic [HW-1:0] r_bar_cnt;
   logic [23:0]   r_data;
   logic          r_de;
   logic          r_hs;
   logic          r_vs;
   logic          r_fs;

   logic          w_step;
   logic          w_origin;
   logic          w_h_last;
   logic          w_v_last;
   logic [HW-1:0] w_h_next;
   logic [VW-1:0] w_v_next;
   logic [1:0]    w_pat;
   logic [23:0]   w_solid;
   logic          w_active;
   logic          w_hs_on;
   logic          w_vs_on;
   logic [3:0]    w_bar_idx;
   logic [23:0]   w_bar_rgb;
   logic [7:0]    w_h8;
   logic          w_v_bit5;
   logic [23:0]   w_pixel;

   always_comb begin
      w_step   = (r_state == StRun) || enable;
      w_origin = (r_h == '0) && (r_v == '0);
      w_h_last = (r_h == H_LAST);
      w_v_last = (r_v == V_LAST);
      w_h_next = w_h_last ? '0 : r_h + HW'(1);
      w_v_next = r_v;
      if (w_h_last) begin
         w_v_next = w_v_last ? '0 : r_v + VW'(1);
      end

      // Pattern and colour take effect from the first pixel of a frame.
      w_pat   = w_origin ? pattern_sel : r_pat;
      w_solid = w_origin ? solid_color : r_solid;

      w_active = (r_h < H_ACT) && (r_v < V_ACT);
      w_hs_on  = (r_h >= HS_BEG) && (r_h < HS_END);
      w_vs_on  = (r_v >= VS_BEG) && (r_v < VS_END);

      w_bar_idx = (BAR_W == 0) ? BAR_NONE : r_bar_idx;
      case (w_bar_idx)
         4'd0:    w_bar_rgb = 24'hFFFFFF;
         4'd1:    w_bar_rgb = 24'hFF00FF;
         4'd2:    w_bar_rgb = 24'h00FFFF;
         4'd3:    w_bar_rgb = 24'h0000FF;
         4'd4:    w_bar_rgb = 24'hFFFF00;
         4'd5:    w_bar_rgb = 24'hFF0000;
         4'd6:    w_bar_rgb = 24'h00FF00;
         default: w_bar_rgb = 24'h000000;
      endcase

      w_h8     = 8'(r_h);
      w_v_bit5 = |(32'(r_v) & 32'd32);

      unique case (w_pat)
         2'd0: w_pixel = w_bar_rgb;
         2'd1: w_pixel = {w_h8, w_h8, w_h8};
         2'd2: w_pixel = (w_h8[5] ^ w_v_bit5) ? 24'h000000 : 24'hFFFFFF;
         2'd3: w_pixel = w_solid;
      endcase
      if (!w_active) begin
         w_pixel = '0;
      end
   end

   always_ff @(posedge PixelClk) begin
      if (pRst) begin
         r_state   <= StIdle;
         r_h       <= '0;
         r_v       <= '0;
         r_pat     <= '0;
         r_solid   <= '0;
         r_bar_idx <= '0;
         r_bar_cnt <= '0;
         r_data    <= '0;
         r_de      <= 1'b0;
         r_hs      <= ~HS_POL;
         r_vs      <= ~VS_POL;
         r_fs      <= 1'b0;
      end else if (w_step) begin
         r_data  <= w_pixel;
         r_de    <= w_active;
         r_hs    <= w_hs_on ? HS_POL : ~HS_POL;
         r_vs    <= w_vs_on ? VS_POL : ~VS_POL;
         r_fs    <= w_origin && w_active;
         r_pat   <= w_pat;
         r_solid <= w_solid;
         r_h     <= w_h_next;
         r_v     <= w_v_next;
         // Only a frame boundary with enable low stops the raster.
         r_state <= (w_h_last && w_v_last && !enable) ? StIdle : StRun;
         if (w_h_last) begin
            r_bar_idx <= '0;
            r_bar_cnt <= '0;
         end else if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= (r_bar_idx == BAR_NONE) ? BAR_NONE : r_bar_idx + 4'd1;
         end else begin
            r_bar_cnt <= r_bar_cnt + HW'(1);
         end
      end else begin
         r_data <= '0;
         r_de   <= 1'b0;
         r_hs   <= ~HS_POL;
         r_vs   <= ~VS_POL;
         r_fs   <= 1'b0;
      end
   end

   assign vid.vid_data         = r_data;
   assign vid.vid_active_video = r_de;
   assign vid.vid_hsync        = r_hs;
   assign vid.vid_vsync        = r_vs;
   assign vid.frame_start      = r_fs;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Self-checking bench: small-raster DUT against a position-based reference model,
// plus a default-parameter DUT for the full-size ramp and checkerboard spot checks.
module tb_vid_pattern_gen;

   localparam int HT = 24;
   localparam int VT = 8;
   localparam int FT = HT * VT;
   localparam logic [27:0] IDLE_O = 28'h0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic [1:0]  pat;
   logic [23:0] solid;
   logic        b_rst, b_en;
   logic [1:0]  b_pat;
   logic [23:0] b_solid;

   int total, bad;

   vid_pattern_gen_if s_if ();
   vid_pattern_gen_if b_if ();

   vid_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_small (
      .PixelClk    (clk),
      .pRst        (rst),
      .enable      (en),
      .pattern_sel (pat),
      .solid_color (solid),
      .vid         (s_if)
   );

   vid_pattern_gen u_big (
      .PixelClk    (clk),
      .pRst        (b_rst),
      .enable      (b_en),
      .pattern_sel (b_pat),
      .solid_color (b_solid),
      .vid         (b_if)
   );

   logic [27:0] obs;
   assign obs = {s_if.vid_data, s_if.vid_active_video, s_if.vid_hsync, s_if.vid_vsync,
                 s_if.frame_start};

   function automatic logic [23:0] bar_colour(int b);
      case (b)
         0:       return 24'hFFFFFF;
         1:       return 24'hFF00FF;
         2:       return 24'h00FFFF;
         3:       return 24'h0000FF;
         4:       return 24'hFFFF00;
         5:       return 24'hFF0000;
         6:       return 24'h00FF00;
         default: return 24'h000000;
      endcase
   endfunction

   // Expected outputs for linear raster position pos of the 16x4 (24x8 total) raster.
   function automatic logic [27:0] ref_out(int pos, logic [1:0] p, logic [23:0] c);
      int x, y;
      logic [23:0] d;
      logic [7:0] xb;
      bit act, hs, vs;
      x  = pos % HT;
      y  = pos / HT;
      xb = x[7:0];
      act = (x < 16) && (y < 4);
      case (p)
         2'd0:    d = bar_colour(x / 2);
         2'd1:    d = {xb, xb, xb};
         2'd2:    d = ((((x / 32) + (y / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
         default: d = c;
      endcase
      if (!act) d = '0;
      hs = (x >= 18) && (x < 21);
      vs = (y >= 5) && (y < 7);
      return {d, act, hs, vs, pos == 0};
   endfunction

   int          m_pos;
   bit          m_run;
   logic [1:0]  m_pat;
   logic [23:0] m_solid;
   logic [27:0] m_exp;

   always @(posedge clk) begin
      if (rst) begin
         m_run   <= 1'b0;
         m_pos   <= 0;
         m_pat   <= '0;
         m_solid <= '0;
         m_exp   <= IDLE_O;
      end else if (m_run || en) begin
         if (m_pos == 0) begin
            m_pat   <= pat;
            m_solid <= solid;
            m_exp   <= ref_out(0, pat, solid);
         end else begin
            m_exp <= ref_out(m_pos, m_pat, m_solid);
         end
         m_pos <= (m_pos + 1) % FT;
         m_run <= !((m_pos == FT - 1) && !en);
      end else begin
         m_exp <= IDLE_O;
      end
   end

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * FT && !ok; i++) begin
         @(negedge clk);
         ok = s_if.frame_start;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      pat = 2'd0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (obs !== IDLE_O) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, IDLE_O);
         end
      end
   endtask

   task automatic test_bars();
      rst = 1'b0;
      for (int k = 0; k < 2 * FT; k++) begin
         @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL bars_model k=%0d got=%h want=%h", k, obs, m_exp);
         end
         if (k < 16) begin
            total++;
            if (obs[27:4] !== bar_colour(k / 2) || obs[3] !== 1'b1) begin
               bad++;
               $display("FAIL bars_px k=%0d got=%h want=%h", k, obs[27:4], bar_colour(k / 2));
            end
         end
         if (k == FT) begin
            total++;
            if (obs[0] !== 1'b1) begin
               bad++;
               $display("FAIL bars_fs_period got=%b want=1", obs[0]);
            end
         end
      end
   endtask

   task automatic test_sync();
      bit ok;
      int vs_first, vs_cnt, hs_cnt, de_cnt;
      vs_first = -1; vs_cnt = 0; hs_cnt = 0; de_cnt = 0;
      en  = 1'b1;
      pat = 2'd0;
      wait_fs(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL sync_wait_fs got=timeout want=frame_start");
      end
      for (int k = 0; k <= FT; k++) begin
         if (k > 0) @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL sync_model k=%0d got=%h want=%h", k, obs, m_exp);
         end
         if (k < FT) begin
            if (s_if.vid_vsync && vs_first < 0) vs_first = k;
            vs_cnt += int'(s_if.vid_vsync);
            hs_cnt += int'(s_if.vid_hsync);
            de_cnt += int'(s_if.vid_active_video);
         end else begin
            total++;
            if (s_if.frame_start !== 1'b1) begin
               bad++;
               $display("FAIL sync_fs_period got=%b want=1", s_if.frame_start);
            end
         end
      end
      total += 4;
      if (vs_first != 120) begin
         bad++; $display("FAIL sync_vs_start got=%0d want=120", vs_first);
      end
      if (vs_cnt != 48) begin
         bad++; $display("FAIL sync_vs_len got=%0d want=48", vs_cnt);
      end
      if (hs_cnt != 24) begin
         bad++; $display("FAIL sync_hs_count got=%0d want=24", hs_cnt);
      end
      if (de_cnt != 64) begin
         bad++; $display("FAIL sync_de_count got=%0d want=64", de_cnt);
      end
   endtask

   task automatic test_pattern_change();
      bit ok;
      en  = 1'b1;
      pat = 2'd0;
      wait_fs(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL patchg_wait_fs got=timeout want=frame_start");
      end
      for (int k = 0; k < 2 * FT; k++) begin
         if (k > 0) @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL patchg_model k=%0d got=%h want=%h", k, obs, m_exp);
         end
         if (k == 60 || k == FT || k == FT + 16) begin
            logic [23:0] want;
            want = (k == 60) ? 24'h00FF00 : (k == FT) ? 24'h123456 : 24'h000000;
            total++;
            if (s_if.vid_data !== want) begin
               bad++;
               $display("FAIL patchg_px k=%0d got=%h want=%h", k, s_if.vid_data, want);
            end
         end
         if (k == 50) begin
            pat   = 2'd3;
            solid = 24'h123456;
         end
      end
   endtask

   task automatic test_enable_off();
      bit ok;
      en  = 1'b1;
      pat = 2'd1;
      wait_fs(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL enoff_wait_fs got=timeout want=frame_start");
      end
      for (int k = 0; k < FT + 30; k++) begin
         if (k > 0) @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL enoff_model k=%0d got=%h want=%h", k, obs, m_exp);
         end
         if (k == 5 * HT) begin
            total++;
            if (s_if.vid_vsync !== 1'b1) begin
               bad++;
               $display("FAIL enoff_frame_runs got=%b want=1", s_if.vid_vsync);
            end
         end
         if (k >= FT) begin
            total++;
            if (obs !== IDLE_O) begin
               bad++;
               $display("FAIL enoff_idle k=%0d got=%h want=%h", k, obs, IDLE_O);
            end
         end
         if (k == 70) en = 1'b0;
      end
      en = 1'b1;
      @(negedge clk);
      total++;
      if (s_if.frame_start !== 1'b1 || s_if.vid_active_video !== 1'b1 || obs !== m_exp) begin
         bad++;
         $display("FAIL enoff_restart got=%h want=%h", obs, m_exp);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      en  = 1'b1;
      pat = 2'd0;
      wait_fs(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rstmid_wait_fs got=timeout want=frame_start");
      end
      n = $urandom_range(20, 150);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL rstmid_model k=%0d got=%h want=%h", k, obs, m_exp);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== IDLE_O) begin
         bad++;
         $display("FAIL rstmid_idle got=%h want=%h", obs, IDLE_O);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (s_if.vid_active_video !== 1'b1 || s_if.frame_start !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_restart got de=%b fs=%b want de=1 fs=1",
                  s_if.vid_active_video, s_if.frame_start);
      end
      for (int k = 0; k < 2 * FT; k++) begin
         @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL rstmid_after k=%0d got=%h want=%h", k, obs, m_exp);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         total++;
         if (obs !== m_exp) begin
            bad++;
            $display("FAIL random_model k=%0d got=%h want=%h", k, obs, m_exp);
         end
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 99) == 0) en = ~en;
         if ($urandom_range(0, 49) == 0) pat = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) solid = 24'($urandom);
      end
      rst = 1'b0;
      en  = 1'b0;
   endtask

   task automatic test_default_raster();
      b_rst = 1'b0; b_en = 1'b1; b_pat = 2'd1;
      @(negedge clk);
      total++;
      if (b_if.vid_active_video !== 1'b1 || b_if.frame_start !== 1'b1 ||
          b_if.vid_data !== 24'h000000) begin
         bad++;
         $display("FAIL big_first_px got de=%b fs=%b d=%h want 1 1 000000",
                  b_if.vid_active_video, b_if.frame_start, b_if.vid_data);
      end
      repeat (300) @(negedge clk);
      total++;
      if (b_if.vid_data !== 24'h2C2C2C) begin
         bad++;
         $display("FAIL big_ramp_300 got=%h want=2c2c2c", b_if.vid_data);
      end
      repeat (980) @(negedge clk);
      total++;
      if (b_if.vid_active_video !== 1'b0 || b_if.vid_data !== 24'h0) begin
         bad++;
         $display("FAIL big_blank_1280 got de=%b d=%h want 0 000000",
                  b_if.vid_active_video, b_if.vid_data);
      end
      b_rst = 1'b1;
      @(negedge clk);
      total++;
      if ({b_if.vid_data, b_if.vid_active_video, b_if.vid_hsync, b_if.vid_vsync,
           b_if.frame_start} !== 28'h0) begin
         bad++;
         $display("FAIL big_reset_idle got d=%h de=%b hs=%b vs=%b", b_if.vid_data,
                  b_if.vid_active_video, b_if.vid_hsync, b_if.vid_vsync);
      end
      b_rst = 1'b0; b_pat = 2'd2;
      @(negedge clk);
      total++;
      if (b_if.vid_data !== 24'hFFFFFF) begin
         bad++;
         $display("FAIL big_chk_0_0 got=%h want=ffffff", b_if.vid_data);
      end
      repeat (32) @(negedge clk);
      total++;
      if (b_if.vid_data !== 24'h000000 || b_if.vid_active_video !== 1'b1) begin
         bad++;
         $display("FAIL big_chk_32_0 got=%h want=000000", b_if.vid_data);
      end
      repeat (32 * 1650) @(negedge clk);
      total++;
      if (b_if.vid_data !== 24'hFFFFFF || b_if.vid_active_video !== 1'b1) begin
         bad++;
         $display("FAIL big_chk_32_32 got=%h want=ffffff", b_if.vid_data);
      end
      b_en = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; en = 1'b0; pat = 2'd0; solid = 24'h0;
      b_rst = 1'b1; b_en = 1'b0; b_pat = 2'd0; b_solid = 24'h0;
      test_reset();
      test_bars();
      test_sync();
      test_pattern_change();
      test_enable_off();
      test_reset_mid();
      test_random();
      test_default_raster();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
